codec_init_sequencer: RTL and testbench

CODEC_INIT_SEQUENCER -- requirements
Module: codec_init_sequencer

---
 rtl/codec_init_sequencer.sv | 228 ++++++++++++++++++++++
 tb/tb_codec_init_sequencer.sv | 329 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/codec_init_sequencer.sv
// Codec power-up register sequencer.
// Waits for the codec supply to settle, then writes a fixed 10-entry register
// table through an external I2C byte master. Each write that is NACKed is
// retried up to MAX_RETRY times before the sequence stops in ERROR.
// A start pulse in DONE or ERROR replays the table without the power-up wait.
module codec_init_sequencer #(
  parameter int         STARTUP_CYCLES = 50000,
  parameter int         GAP_CYCLES     = 256,
  parameter int         MAX_RETRY      = 3,
  parameter logic [6:0] DEV_ADDR       = 7'h1A
) (
  input  logic        clk_clk,
  input  logic        reset_reset_n,
  input  logic        start,
  output logic        i2c_req,
  output logic [6:0]  i2c_addr,
  output logic [15:0] i2c_data,
  input  logic        i2c_done,
  input  logic        i2c_nack,
  output logic        busy,
  output logic        init_done,
  output logic        init_error,
  output logic [3:0]  err_index
);

  // One counter serves both the power-up wait and the inter-transaction gap.
  localparam int CNT_MAX = (STARTUP_CYCLES > GAP_CYCLES) ? STARTUP_CYCLES : GAP_CYCLES;
  localparam int CW      = $clog2(CNT_MAX + 2);
  localparam int RW      = $clog2(MAX_RETRY + 2);

  localparam logic [CW-1:0] STARTUP_LAST = CW'(STARTUP_CYCLES - 1);
  localparam logic [CW-1:0] GAP_LAST     = CW'(GAP_CYCLES - 1);
  localparam logic [RW-1:0] RETRY_LIMIT  = RW'(MAX_RETRY);
  localparam logic [3:0]    LAST_INDEX   = 4'd9;

  typedef enum logic [2:0] {
    WAIT_PWR = 3'd0,
    LOAD     = 3'd1,
    REQ      = 3'd2,
    CHECK    = 3'd3,
    GAP      = 3'd4,
    DONE     = 3'd5,
    ERROR    = 3'd6
  } state_t;

  state_t          state_r;
  state_t          state_s;
  logic [CW-1:0]   cnt_r;
  logic [3:0]      index_r;
  logic [RW-1:0]   retry_r;
  logic            nack_r;
  logic [15:0]     data_r;
  logic [3:0]      err_index_r;
  logic            req_r;
  logic            busy_r;
  logic            done_r;
  logic            error_r;
  logic            req_s;
  logic            busy_s;
  logic            done_s;
  logic            error_s;

  // Codec register table: {reg_addr[6:0], reg_data[8:0]}.
  function automatic logic [15:0] table_word(input logic [3:0] idx);
    logic [15:0] word;
    case (idx)
      4'd0:    word = 16'h1E00;  // reset
      4'd1:    word = 16'h0017;
      4'd2:    word = 16'h0217;
      4'd3:    word = 16'h0479;
      4'd4:    word = 16'h0679;
      4'd5:    word = 16'h0812;  // DAC select
      4'd6:    word = 16'h0A00;
      4'd7:    word = 16'h0C00;
      4'd8:    word = 16'h0E42;  // codec master, I2S, 16-bit
      4'd9:    word = 16'h1201;  // active
      default: word = 16'h0000;
    endcase
    return word;
  endfunction

  // State register.
  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      state_r <= WAIT_PWR;
    end else begin
      state_r <= state_s;
    end
  end

  // Next-state logic; start only matters once the sequence has finished.
  always_comb begin
    state_s = state_r;
    case (state_r)
      WAIT_PWR: begin
        if (cnt_r == STARTUP_LAST) state_s = LOAD;
        else                       state_s = WAIT_PWR;
      end
      LOAD: state_s = REQ;
      REQ: begin
        if (i2c_done) state_s = CHECK;
        else          state_s = REQ;
      end
      CHECK: begin
        if (!nack_r) begin
          if (index_r == LAST_INDEX) state_s = DONE;
          else                       state_s = GAP;
        end else begin
          if (retry_r < RETRY_LIMIT) state_s = GAP;
          else                       state_s = ERROR;
        end
      end
      GAP: begin
        if (cnt_r == GAP_LAST) state_s = LOAD;
        else                   state_s = GAP;
      end
      DONE: begin
        if (start) state_s = LOAD;
        else       state_s = DONE;
      end
      ERROR: begin
        if (start) state_s = LOAD;
        else       state_s = ERROR;
      end
      default: state_s = WAIT_PWR;
    endcase
  end

  // Output decode from the next state so the registered outputs track the state.
  always_comb begin
    req_s   = 1'b0;
    busy_s  = 1'b1;
    done_s  = 1'b0;
    error_s = 1'b0;
    case (state_s)
      REQ:     req_s   = 1'b1;
      DONE: begin
        busy_s = 1'b0;
        done_s = 1'b1;
      end
      ERROR: begin
        busy_s  = 1'b0;
        error_s = 1'b1;
      end
      default: begin
        req_s   = 1'b0;
        busy_s  = 1'b1;
        done_s  = 1'b0;
        error_s = 1'b0;
      end
    endcase
  end

  // Output registers; reset values apply asynchronously.
  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      req_r   <= 1'b0;
      busy_r  <= 1'b1;
      done_r  <= 1'b0;
      error_r <= 1'b0;
    end else begin
      req_r   <= req_s;
      busy_r  <= busy_s;
      done_r  <= done_s;
      error_r <= error_s;
    end
  end

  // Wait counter: restarts on every state change, advances only while timing.
  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      cnt_r <= '0;
    end else if (state_s != state_r) begin
      cnt_r <= '0;
    end else if ((state_r == WAIT_PWR) || (state_r == GAP)) begin
      cnt_r <= cnt_r + CW'(1'b1);
    end else begin
      cnt_r <= cnt_r;
    end
  end

  // Sequencing datapath: table index, retry count, NACK latch, data and error index.
  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      index_r     <= 4'd0;
      retry_r     <= '0;
      nack_r      <= 1'b0;
      data_r      <= 16'h0000;
      err_index_r <= 4'd0;
    end else begin
      case (state_r)
        LOAD: data_r <= table_word(index_r);
        REQ: begin
          if (i2c_done) nack_r <= i2c_nack;
        end
        CHECK: begin
          if (!nack_r) begin
            retry_r <= '0;
            if (index_r != LAST_INDEX) index_r <= index_r + 4'd1;
          end else if (retry_r < RETRY_LIMIT) begin
            retry_r <= retry_r + RW'(1'b1);
          end else begin
            err_index_r <= index_r;
          end
        end
        DONE, ERROR: begin
          if (start) begin
            index_r     <= 4'd0;
            retry_r     <= '0;
            err_index_r <= 4'd0;
          end
        end
        default: begin
          index_r <= index_r;
        end
      endcase
    end
  end

  assign i2c_req    = req_r;
  assign i2c_addr   = DEV_ADDR;
  assign i2c_data   = data_r;
  assign busy       = busy_r;
  assign init_done  = done_r;
  assign init_error = error_r;
  assign err_index  = err_index_r;

endmodule

// File: tb/tb_codec_init_sequencer.sv
// Bench for codec_init_sequencer: a behavioural I2C master answers requests
// with random latency and a per-entry NACK plan; the expected write list and
// end state are derived from the plan and the retry rule.
module tb_codec_init_sequencer;

  localparam int STARTUP = 20;
  localparam int GAPC    = 4;
  localparam int MAXR    = 3;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        start = 1'b0;
  logic        i2c_done = 1'b0;
  logic        i2c_nack = 1'b0;
  logic        i2c_req;
  logic [6:0]  i2c_addr;
  logic [15:0] i2c_data;
  logic        busy;
  logic        init_done;
  logic        init_error;
  logic [3:0]  err_index;

  int          checks = 0;
  int          failures = 0;
  logic [15:0] words [10];
  int          nack_plan [10];
  int          attempts [10];
  logic [15:0] log_q [$];
  logic [15:0] exp_q [$];
  int          lat_min = 1;
  int          lat_max = 1;
  bit          start_pending = 1'b0;
  bit          start_with_done = 1'b0;
  bit          spurious_en = 1'b0;

  codec_init_sequencer #(
    .STARTUP_CYCLES(STARTUP),
    .GAP_CYCLES(GAPC),
    .MAX_RETRY(MAXR),
    .DEV_ADDR(7'h1A)
  ) dut (
    .clk_clk(clk),
    .reset_reset_n(rst_n),
    .start(start),
    .i2c_req(i2c_req),
    .i2c_addr(i2c_addr),
    .i2c_data(i2c_data),
    .i2c_done(i2c_done),
    .i2c_nack(i2c_nack),
    .busy(busy),
    .init_done(init_done),
    .init_error(init_error),
    .err_index(err_index)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int word_index(input logic [15:0] w);
    for (int i = 0; i < 10; i++) if (words[i] == w) return i;
    return -1;
  endfunction

  // Behavioural I2C master plus per-cycle invariant checks.
  initial begin : responder
    bit          in_txn;
    bit          sent;
    int          idx;
    int          wait_left;
    logic [15:0] cur;
    in_txn = 1'b0; sent = 1'b0; idx = -1; wait_left = 0; cur = 16'h0000;
    forever begin
      @(negedge clk);
      i2c_done = 1'b0;
      i2c_nack = 1'b0;
      start    = 1'b0;
      if (!rst_n) begin
        in_txn = 1'b0;
      end else begin
        check_eq("done_error_exclusive", {31'd0, init_done & init_error}, 32'd0);
        check_eq("busy_vs_final", {31'd0, busy}, {31'd0, ~(init_done | init_error)});
        if (i2c_req) begin
          if (!in_txn) begin
            in_txn = 1'b1;
            sent   = 1'b0;
            cur    = i2c_data;
            log_q.push_back(cur);
            idx = word_index(cur);
            if (idx >= 0) attempts[idx]++;
            wait_left = int'($urandom_range(lat_max, lat_min)) - 1;
          end else begin
            check_eq("data_stable", {16'd0, i2c_data}, {16'd0, cur});
          end
          if (!sent) begin
            if (wait_left <= 0) begin
              i2c_done = 1'b1;
              i2c_nack = (idx >= 0) && (attempts[idx] <= nack_plan[idx]);
              sent = 1'b1;
              if (start_with_done) begin
                start = 1'b1;
                start_with_done = 1'b0;
              end
            end else begin
              wait_left--;
            end
          end
        end else begin
          in_txn = 1'b0;
          if (spurious_en && busy && ($urandom_range(0, 5) == 0)) begin
            i2c_done = 1'b1;
            i2c_nack = 1'b1;
          end
        end
        if (start_pending) begin
          start = 1'b1;
          start_pending = 1'b0;
        end
      end
    end
  end

  task automatic clear_plan();
    for (int i = 0; i < 10; i++) nack_plan[i] = 0;
  endtask

  task automatic clear_log();
    log_q.delete();
    for (int i = 0; i < 10; i++) attempts[i] = 0;
  endtask

  // Hold reset for a few cycles; release on a falling edge.
  task automatic apply_reset();
    @(negedge clk);
    #1 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    clear_log();
    rst_n = 1'b1;
  endtask

  // Count rising edges until i2c_req is seen high; -1 on timeout.
  task automatic wait_req_rise(output int n);
    n = -1;
    for (int i = 1; i <= 200; i++) begin
      @(posedge clk);
      #1;
      if (i2c_req) begin
        n = i;
        break;
      end
    end
  endtask

  // Reference: writes follow the table; each entry is sent once per NACK up
  // to MAX_RETRY retries; an entry NACKed more often than that ends the run.
  task automatic build_expected(output bit exp_err, output int exp_eidx);
    exp_q.delete();
    exp_err = 1'b0;
    exp_eidx = 0;
    for (int i = 0; i < 10; i++) begin
      int sends;
      sends = (nack_plan[i] > MAXR) ? MAXR + 1 : nack_plan[i] + 1;
      for (int k = 0; k < sends; k++) exp_q.push_back(words[i]);
      if (nack_plan[i] > MAXR) begin
        exp_err = 1'b1;
        exp_eidx = i;
        break;
      end
    end
  endtask

  task automatic run_check(input string tag);
    bit exp_err;
    int exp_eidx;
    int n;
    int got;
    got = 0;
    for (int i = 0; i < 4000; i++) begin
      @(posedge clk);
      #1;
      if (!busy) begin
        got = 1;
        break;
      end
    end
    check_eq({tag, "_finished"}, got, 32'd1);
    build_expected(exp_err, exp_eidx);
    check_eq({tag, "_write_count"}, log_q.size(), exp_q.size());
    n = (log_q.size() < exp_q.size()) ? log_q.size() : exp_q.size();
    for (int i = 0; i < n; i++)
      check_eq($sformatf("%s_word%0d", tag, i), {16'd0, log_q[i]}, {16'd0, exp_q[i]});
    check_eq({tag, "_init_done"}, {31'd0, init_done}, {31'd0, ~exp_err});
    check_eq({tag, "_init_error"}, {31'd0, init_error}, {31'd0, exp_err});
    check_eq({tag, "_err_index"}, {28'd0, err_index}, exp_err ? exp_eidx : 0);
    check_eq({tag, "_req_low"}, {31'd0, i2c_req}, 32'd0);
    repeat (40) @(posedge clk);
    #1;
    check_eq({tag, "_no_extra_writes"}, log_q.size(), exp_q.size());
    check_eq({tag, "_stays_idle"}, {31'd0, busy}, 32'd0);
  endtask

  // Pulse start in DONE/ERROR and expect an immediate replay.
  task automatic restart_check(input string tag);
    int n;
    clear_log();
    @(posedge clk);
    #1 start_pending = 1'b1;
    @(posedge clk);
    @(posedge clk);
    #1;
    check_eq({tag, "_busy_after_start"}, {31'd0, busy}, 32'd1);
    check_eq({tag, "_done_cleared"}, {31'd0, init_done}, 32'd0);
    check_eq({tag, "_error_cleared"}, {31'd0, init_error}, 32'd0);
    check_eq({tag, "_err_index_cleared"}, {28'd0, err_index}, 32'd0);
    wait_req_rise(n);
    check_eq({tag, "_req_latency"}, n, 32'd1);
  endtask

  initial begin : main
    int n;
    words = '{16'h1E00, 16'h0017, 16'h0217, 16'h0479, 16'h0679,
              16'h0812, 16'h0A00, 16'h0C00, 16'h0E42, 16'h1201};
    clear_plan();
    clear_log();

    // Reset values are visible before any clock edge.
    #2 rst_n = 1'b0;
    #1;
    check_eq("rst_req", {31'd0, i2c_req}, 32'd0);
    check_eq("rst_data", {16'd0, i2c_data}, 32'd0);
    check_eq("rst_addr", {25'd0, i2c_addr}, 32'h1A);
    check_eq("rst_busy", {31'd0, busy}, 32'd1);
    check_eq("rst_done", {31'd0, init_done}, 32'd0);
    check_eq("rst_error", {31'd0, init_error}, 32'd0);
    check_eq("rst_err_index", {28'd0, err_index}, 32'd0);

    // Clean run, fixed 10-cycle ACK latency.
    lat_min = 10; lat_max = 10;
    apply_reset();
    wait_req_rise(n);
    check_eq("clean_first_req", n, 32'd21);
    run_check("clean");

    // Index 3 NACKed twice, then ACKed.
    lat_min = 1; lat_max = 8;
    clear_plan();
    nack_plan[3] = 2;
    apply_reset();
    run_check("retry3");

    // Index 5 never ACKed; then a start from ERROR replays cleanly.
    clear_plan();
    nack_plan[5] = 1000;
    apply_reset();
    run_check("fail5");
    clear_plan();
    restart_check("from_error");
    run_check("after_error");

    // start while busy is ignored; start in DONE replays without power-up wait.
    lat_min = 6; lat_max = 6;
    clear_plan();
    nack_plan[2] = 1;
    nack_plan[7] = 2;
    apply_reset();
    repeat (60) @(posedge clk);
    #1;
    check_eq("busy_start_in_progress", {31'd0, busy}, 32'd1);
    start_pending = 1'b1;
    run_check("busy_start");
    clear_plan();
    restart_check("from_done");
    run_check("after_done");

    // start coinciding with i2c_done in REQ.
    lat_min = 1; lat_max = 5;
    clear_plan();
    apply_reset();
    start_with_done = 1'b1;
    run_check("start_with_done");
    check_eq("start_with_done_consumed", {31'd0, start_with_done}, 32'd0);

    // Reset while index 6 is being requested.
    lat_min = 30; lat_max = 30;
    apply_reset();
    n = 0;
    for (int i = 0; i < 2000; i++) begin
      @(negedge clk);
      if (i2c_req && (i2c_data == words[6])) begin
        n = 1;
        break;
      end
    end
    check_eq("idx6_reached", n, 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check_eq("midreset_req", {31'd0, i2c_req}, 32'd0);
    check_eq("midreset_busy", {31'd0, busy}, 32'd1);
    check_eq("midreset_data", {16'd0, i2c_data}, 32'd0);
    repeat (3) @(negedge clk);
    clear_log();
    lat_min = 1; lat_max = 6;
    rst_n = 1'b1;
    wait_req_rise(n);
    check_eq("midreset_first_req", n, 32'd21);
    run_check("midreset_rerun");

    // Random NACK plans with stray i2c_done pulses outside REQ.
    spurious_en = 1'b1;
    lat_min = 1; lat_max = 12;
    for (int r = 0; r < 4; r++) begin
      for (int i = 0; i < 10; i++)
        nack_plan[i] = ($urandom_range(0, 11) == 0) ? 4 : int'($urandom_range(0, 2));
      apply_reset();
      run_check($sformatf("random%0d", r));
    end
    spurious_en = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
